button_switch_reader: RTL and testbench

BUTTON_SWITCH_READER -- requirements
Module: button_switch_reader

---
 rtl/button_switch_reader_pkg.sv | 39 +++
 rtl/button_switch_reader_debounce.sv | 57 +++++
 rtl/button_switch_reader.sv | 110 +++++++++++
 tb/tb_button_switch_reader.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_switch_reader_pkg.sv
// Shared address map, register offsets and reset constants for the button/switch reader peripheral.
// Also provides the word-address decoder used by the register window.
package button_switch_reader_pkg;

    localparam logic [31:0] BSR_BASE_ADDR = 32'h7000_0000;

    localparam logic [31:0] BSR_OFF_SW   = 32'h0000_0000;
    localparam logic [31:0] BSR_OFF_BTN  = 32'h0000_0004;
    localparam logic [31:0] BSR_OFF_EDGE = 32'h0000_0008;

    localparam int unsigned NUM_SW     = 8;
    localparam int unsigned NUM_BTN    = 4;
    localparam int unsigned NUM_INPUTS = NUM_SW + NUM_BTN;

    localparam logic [31:0]           BSR_RDATA_RST = 32'h0000_0000;
    localparam logic [NUM_BTN-1:0]    BSR_EDGE_RST  = '0;
    localparam logic                  BSR_FLAG_RST  = 1'b0;

    typedef enum logic [1:0] {
        REG_SW   = 2'd0,
        REG_BTN  = 2'd1,
        REG_EDGE = 2'd2,
        REG_NONE = 2'd3
    } reg_sel_e;

    // Caller passes a word-aligned address; anything outside the three words decodes to REG_NONE.
    function automatic reg_sel_e decode_reg(input logic [31:0] word_addr,
                                            input logic [31:0] base);
        logic [31:0] offset;
        offset = word_addr - base;
        case (offset)
            BSR_OFF_SW:   return REG_SW;
            BSR_OFF_BTN:  return REG_BTN;
            BSR_OFF_EDGE: return REG_EDGE;
            default:      return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/button_switch_reader_debounce.sv
// One input channel: 2-flop synchronizer followed by a stability counter that
// accepts a new level after DEBOUNCE_CYCLES consecutive disagreeing samples.
module debounce_cell #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] COUNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_reg;
    logic          sync_reg;
    logic          level_reg;
    logic          level_next;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          accept;

    assign accept = (sync_reg != level_reg) && (count_reg == COUNT_MAX);

    always_comb begin
        count_next = count_reg;
        level_next = level_reg;
        if (sync_reg == level_reg) begin
            count_next = '0;
        end else if (accept) begin
            level_next = sync_reg;
            count_next = '0;
        end else begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_reg  <= 1'b0;
            sync_reg  <= 1'b0;
            level_reg <= 1'b0;
            count_reg <= '0;
        end else begin
            meta_reg  <= raw;
            sync_reg  <= meta_reg;
            level_reg <= level_next;
            count_reg <= count_next;
        end
    end

    assign level = level_reg;
    // Combinational so the edge flag sets on the same clock edge the level flips.
    assign rise  = accept & sync_reg;

endmodule

// File: rtl/button_switch_reader.sv
// Memory-mapped reader for 8 slide switches and 4 push buttons with debouncing,
// sticky rising-edge flags on the buttons and a level interrupt.
module button_switch_reader
    import button_switch_reader_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic [31:0] BASE_ADDR       = BSR_BASE_ADDR
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 re_i,
    input  logic                 we_i,
    input  logic [31:0]          addr_i,
    input  logic [31:0]          wdata_i,
    input  logic [NUM_BTN-1:0]   btn_i,
    input  logic [NUM_SW-1:0]    sw_i,
    output logic [31:0]          rdata_o,
    output logic                 rvalid_o,
    output logic                 irq_o
);

    logic [NUM_INPUTS-1:0] raw;
    logic [NUM_INPUTS-1:0] level;
    logic [NUM_INPUTS-1:0] rise;

    // Switches occupy the low bits, buttons the high bits.
    assign raw = {btn_i, sw_i};

    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_cell
            debounce_cell #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_cell (
                .clk  (clk_i),
                .rst_n(rst_ni),
                .raw  (raw[gi]),
                .level(level[gi]),
                .rise (rise[gi])
            );
        end
    endgenerate

    logic [NUM_SW-1:0]  sw_level;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_rise;

    assign sw_level  = level[NUM_SW-1:0];
    assign btn_level = level[NUM_INPUTS-1:NUM_SW];
    assign btn_rise  = rise[NUM_INPUTS-1:NUM_SW];

    logic unused_bits;
    assign unused_bits = ^{rise[NUM_SW-1:0], addr_i[1:0], wdata_i[31:NUM_BTN]};

    reg_sel_e sel;
    logic     rd;
    logic     wr;

    assign sel = decode_reg({addr_i[31:2], 2'b00}, BASE_ADDR);
    assign rd  = en_i & re_i;
    assign wr  = en_i & we_i;

    logic [NUM_BTN-1:0] edge_reg;
    logic [NUM_BTN-1:0] edge_next;
    logic [NUM_BTN-1:0] edge_clear;
    logic [31:0]        read_mux;
    logic [31:0]        rdata_reg;
    logic               rvalid_reg;
    logic               irq_reg;

    always_comb begin
        read_mux = 32'h0;
        case (sel)
            REG_SW:   read_mux = 32'(sw_level);
            REG_BTN:  read_mux = 32'(btn_level);
            REG_EDGE: read_mux = 32'(edge_reg);
            default:  read_mux = 32'h0;
        endcase
    end

    // A rising edge arriving with a clear of the same bit keeps the flag set.
    always_comb begin
        edge_clear = '0;
        if (wr && (sel == REG_EDGE)) begin
            edge_clear = wdata_i[NUM_BTN-1:0];
        end
        edge_next = (edge_reg & ~edge_clear) | btn_rise;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            edge_reg   <= BSR_EDGE_RST;
            rdata_reg  <= BSR_RDATA_RST;
            rvalid_reg <= BSR_FLAG_RST;
            irq_reg    <= BSR_FLAG_RST;
        end else begin
            edge_reg   <= edge_next;
            irq_reg    <= |edge_reg;
            rvalid_reg <= rd;
            if (rd) begin
                rdata_reg <= read_mux;
            end
        end
    end

    assign rdata_o  = rdata_reg;
    assign rvalid_o = rvalid_reg;
    assign irq_o    = irq_reg;

endmodule

// File: tb/tb_button_switch_reader.sv
// Randomized and directed bench for button_switch_reader against a behavioural
// model that accepts a new level once a full window of synchronized samples disagrees.
module tb_button_switch_reader;

    localparam int unsigned DEB  = 16;
    localparam logic [31:0] BASE = 32'h7000_0000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        re    = 1'b0;
    logic        we    = 1'b0;
    logic [31:0] addr  = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  btn   = 4'h0;
    logic [7:0]  sw    = 8'h0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    button_switch_reader #(
        .DEBOUNCE_CYCLES(DEB),
        .BASE_ADDR      (BASE)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .en_i    (en),
        .re_i    (re),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
        .btn_i   (btn),
        .sw_i    (sw),
        .rdata_o (rdata),
        .rvalid_o(rvalid),
        .irq_o   (irq)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [11:0] lvl_m    = 12'h0;
    logic [3:0]  edge_m   = 4'h0;
    logic [31:0] rdata_m  = 32'h0;
    logic        rvalid_m = 1'b0;
    logic        irq_m    = 1'b0;
    logic [11:0] raw_pipe[$];
    logic [11:0] samp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'h3;
        if (w == BASE)                 return {24'h0, lvl_m[7:0]};
        else if (w == BASE + 32'd4)    return {28'h0, lvl_m[11:8]};
        else if (w == BASE + 32'd8)    return {28'h0, edge_m};
        return 32'h0;
    endfunction

    task automatic model_edge();
        logic [11:0] sample;
        logic [11:0] old_lvl;
        logic [11:0] new_lvl;
        logic [3:0]  clr;
        logic [3:0]  rise;
        bit          all_diff;
        if (!rst_n) begin
            lvl_m = 12'h0; edge_m = 4'h0; rdata_m = 32'h0; rvalid_m = 1'b0; irq_m = 1'b0;
            raw_pipe = {12'h0, 12'h0};
            samp_q = {};
            return;
        end
        // Inputs become visible to the debouncer two edges after they are sampled.
        sample = raw_pipe.pop_front();
        raw_pipe.push_back({btn, sw});
        samp_q.push_back(sample);
        if (samp_q.size() > DEB) void'(samp_q.pop_front());
        old_lvl = lvl_m;
        new_lvl = lvl_m;
        if (samp_q.size() == DEB) begin
            for (int b = 0; b < 12; b++) begin
                all_diff = 1'b1;
                for (int i = 0; i < DEB; i++) begin
                    if (samp_q[i][b] == old_lvl[b]) all_diff = 1'b0;
                end
                if (all_diff) new_lvl[b] = ~old_lvl[b];
            end
        end
        rise = new_lvl[11:8] & ~old_lvl[11:8];
        if (en && re) begin
            rdata_m  = model_read(addr);
            rvalid_m = 1'b1;
        end else begin
            rvalid_m = 1'b0;
        end
        clr = (en && we && ((addr & ~32'h3) == BASE + 32'd8)) ? wdata[3:0] : 4'h0;
        irq_m  = |edge_m;
        edge_m = (edge_m & ~clr) | rise;
        lvl_m  = new_lvl;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_val("rvalid", 32'(rvalid), 32'(rvalid_m));
        check_val("rdata", rdata, rdata_m);
        check_val("irq", 32'(irq), 32'(irq_m));
    endtask

    task automatic idle(input int n);
        en = 1'b0; re = 1'b0; we = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        en = 1'b1; re = 1'b1; we = 1'b0; addr = a;
        cycle();
        en = 1'b0; re = 1'b0;
        d = rdata;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] wd);
        en = 1'b1; re = 1'b0; we = 1'b1; addr = a; wdata = wd;
        cycle();
        en = 1'b0; we = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) cycle();
        rst_n = 1'b1;
    endtask

    task automatic rand_bus();
        int pick;
        en    = ($urandom_range(0, 3) != 0);
        re    = $urandom_range(0, 1) == 1;
        we    = $urandom_range(0, 1) == 1;
        pick  = $urandom_range(0, 4);
        addr  = (pick < 4) ? BASE + 32'(pick) * 32'd4 + 32'($urandom_range(0, 3)) : 32'($urandom);
        wdata = 32'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        d = 32'h0;

        do_reset(3);
        check_val("rst_rvalid", 32'(rvalid), 32'h0);
        check_val("rst_irq", 32'(irq), 32'h0);
        bus_read(BASE, d);
        check_val("rst_sw", d, 32'h0);
        check_val("rst_rd_valid", 32'(rvalid), 32'h1);
        bus_read(BASE + 32'd4, d);
        check_val("rst_btn", d, 32'h0);
        bus_read(BASE + 32'd8, d);
        check_val("rst_edge", d, 32'h0);
        idle(1);
        check_val("rvalid_pulse", 32'(rvalid), 32'h0);

        sw = 8'hA5;
        idle(20);
        bus_read(BASE, d);
        check_val("sw_a5", d, 32'h0000_00A5);
        sw = 8'h00;
        idle(20);
        sw = 8'hA5;
        idle(10);
        sw = 8'h00;
        idle(20);
        bus_read(BASE, d);
        check_val("sw_short", d, 32'h0);

        btn = 4'h4;
        idle(1);
        btn = 4'h0;
        idle(4);
        bus_read(BASE + 32'd4, d);
        check_val("glitch_btn", d, 32'h0);
        btn = 4'h4;
        idle(20);
        bus_read(BASE + 32'd4, d);
        check_val("btn_4", d, 32'h4);
        bus_read(BASE + 32'd8, d);
        check_val("edge_4", d, 32'h4);
        check_val("irq_set", 32'(irq), 32'h1);

        btn = 4'h5;
        idle(20);
        bus_read(BASE + 32'd8, d);
        check_val("edge_5", d, 32'h5);
        bus_write(BASE + 32'd8, 32'h1);
        bus_read(BASE + 32'd8, d);
        check_val("edge_clr1", d, 32'h4);
        check_val("irq_hold", 32'(irq), 32'h1);
        bus_write(BASE + 32'd8, 32'h4);
        check_val("irq_lag", 32'(irq), 32'h1);
        idle(1);
        check_val("irq_clear", 32'(irq), 32'h0);

        // Clear on the exact accepting edge: first differing sample at edge 3, accept at edge DEB+2.
        btn = 4'h0;
        idle(20);
        bus_read(BASE + 32'd8, d);
        check_val("edge_fall", d, 32'h0);
        btn = 4'h1;
        idle(DEB + 1);
        bus_write(BASE + 32'd8, 32'h1);
        bus_read(BASE + 32'd8, d);
        check_val("set_wins", d, 32'h1);
        bus_write(BASE + 32'd8, 32'h1);
        idle(1);

        sw = 8'h3C;
        idle(20);
        bus_read(BASE + 32'd12, d);
        check_val("unmapped_rd", d, 32'h0);
        bus_write(BASE, 32'hFFFF_FFFF);
        bus_write(BASE + 32'd4, 32'hFFFF_FFFF);
        bus_read(BASE, d);
        check_val("sw_ro", d, 32'h3C);
        bus_read(BASE + 32'd4, d);
        check_val("btn_ro", d, 32'h1);

        btn = 4'h3;
        idle(20);
        en = 1'b1; re = 1'b1; we = 1'b1; addr = BASE + 32'd8; wdata = 32'h2;
        cycle();
        en = 1'b0; re = 1'b0; we = 1'b0;
        check_val("rw_read_first", rdata, 32'h2);
        bus_read(BASE + 32'd8, d);
        check_val("rw_cleared", d, 32'h0);

        sw = 8'hFF;
        idle(8);
        rst_n = 1'b0;
        cycle();
        check_val("mid_rst_rdata", rdata, 32'h0);
        check_val("mid_rst_rvalid", 32'(rvalid), 32'h0);
        check_val("mid_rst_irq", 32'(irq), 32'h0);
        cycle();
        rst_n = 1'b1;
        idle(DEB);
        bus_read(BASE, d);
        check_val("count_restart", d, 32'h0);
        idle(2);
        bus_read(BASE, d);
        check_val("after_restart", d, 32'hFF);

        for (int it = 0; it < 150; it++) begin
            int hold;
            if ($urandom_range(0, 2) == 0) sw = 8'($urandom);
            if ($urandom_range(0, 2) == 0) btn = 4'($urandom);
            hold = (it % 4 == 0) ? $urandom_range(1, 4) : $urandom_range(DEB, DEB + 24);
            for (int c = 0; c < hold; c++) begin
                rand_bus();
                cycle();
            end
            if (it % 50 == 49) begin
                en = 1'b0; re = 1'b0; we = 1'b0;
                do_reset(2);
            end
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
